cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller. Sits directly downstream of the CPU read/write transaction generator and consumes its Address, wr_rd, cs and DOut.
- Owns tag/valid/dirty state for 8 lines of 32 bytes.
- Drives a 256x8 synchronous cache SRAM and a byte-wide main-memory (SDRAM controller) strobe interface.
- Address split: tag = addr[15:8], index = addr[7:5], offset = addr[4:0].

Parameters:
MEM_WAIT, 4, cycles waited after each mem_strb pulse before the next word step. Read data is sampled on the last wait cycle. Legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-low (0 = reset)
cpu_addr  in  16  CPU address
cpu_wr_rd  in  1  1 = write, 0 = read
cpu_cs  in  1  chip select; a request is its rising edge
cpu_dout  in  8  CPU write data
cpu_din  out  8  read data returned to CPU
cpu_rdy  out  1  1 = idle/complete, 0 = busy
sram_addr  out  8  cache SRAM address {index, offset}
sram_din  out  8  cache SRAM write data
sram_dout  in  8  cache SRAM read data, 1-cycle latency
sram_wen  out  1  cache SRAM write enable
mem_addr  out  16  main-memory address
mem_din  out  8  write data to memory
mem_dout  in  8  read data from memory
mem_wr_rd  out  1  1 = write, 0 = read
mem_strb  out  1  one-cycle transfer strobe

Behaviour:
Reset (rst=0 at a clk edge), whether idle or mid-operation:
- State goes to IDLE.
- All valid and dirty bits cleared; tags set to 0.
- cpu_rdy=1; cpu_din=0.
- sram_wen=0; sram_addr=0; sram_din=0.
- mem_strb=0; mem_wr_rd=0; mem_addr=0; mem_din=0.
- cs_prev=0.
- An interrupted fill leaves its line invalid.

Accept:
- In IDLE, cpu_cs=1 with cs_prev=0 at edge E0 latches addr, wr_rd and data, sets cpu_rdy=0 and moves to COMPARE.
- cs_prev tracks cpu_cs every cycle.
- Rising edges seen outside IDLE are dropped, not queued.
- cs held high never re-triggers.

COMPARE (E1): hit = valid[idx] and tag[idx]==req_tag.
- Write hit: sram_wen=1, sram_addr={idx,off}, sram_din=req_data; dirty[idx]=1; go to DONE.
- Read hit: sram_addr={idx,off}; go to RD_WAIT.
- Miss with valid and dirty line: word counter k=0; go to WB_RD.
- Miss with invalid or clean line: k=0; go to FILL_STRB.

RD_WAIT (E2): cpu_din <= sram_dout; go to IDLE with cpu_rdy=1.

DONE (E2): go to IDLE with cpu_rdy=1.
- Both hit types therefore complete with cpu_rdy=1 two edges after accept.

Write-back loop, per word k (k=0..31):
- WB_RD: sram_addr={idx,k}.
- WB_STRB: mem_addr={old_tag,idx,k}, mem_din=sram_dout, mem_wr_rd=1, mem_strb=1 for exactly one cycle.
- WB_WAIT: MEM_WAIT cycles.
- Then k++. After k=31, reset k=0 and go to FILL_STRB.
- Cost: (2+MEM_WAIT) cycles per word.

Fill loop, per word k (k=0..31):
- FILL_STRB: mem_addr={req_tag,idx,k}, mem_wr_rd=0, mem_strb=1 for one cycle.
- FILL_WAIT: MEM_WAIT cycles; capture mem_dout on the last cycle.
- FILL_WR: sram_wen=1, sram_addr={idx,k}, sram_din=captured byte.
- Cost: (2+MEM_WAIT) cycles per word.
- After k=31: tag[idx]=req_tag, valid=1, dirty=0, then return to COMPARE. The request now hits.

Other rules:
- mem_strb and sram_wen are 0 in every state not listed above.
- Word counter is 5 bits. Offsets wrap 0x1F to 0x00 only at loop end; the counter never crosses the line boundary.
- cpu_din holds its last value until the next read completes.

Test Plan:
1. Hold rst=0 for 5 cycles while toggling cpu_cs -> no mem_strb or sram_wen, cpu_rdy=1, all outputs 0. Release -> first cs rise is accepted.
2. Cold write 0x1100, data 0xAA (MEM_WAIT=4) -> 32 reads at 0x1100..0x111F, no memory writes, SRAM[0x00]=0xAA. cpu_rdy returns 32*6+1+2 cycles after accept.
3. Write 0x1102/0xBB, then read 0x1100, then read 0x1102 -> no mem_strb; cpu_din=0xAA then 0xBB; cpu_rdy=1 two edges after each accept.
4. Write 0x5504/0x99 (index 0, dirty) -> 32 memory writes at 0x1100..0x111F carrying 0xAA at 0x1100 and 0xBB at 0x1102. Then 32 reads at 0x5500..0x551F, SRAM[0x04]=0x99, dirty set. A following read of 0x6606 write-backs to 0x5500.. with 0x99 at 0x5504.
5. Read 0x3346, then read 0x4444 (both index 2, clean) -> second miss issues 32 reads only, no writes; cpu_din equals the memory model byte at 0x4444.
6. During a fill, pulse cpu_cs again -> ignored. Assert rst at k=10, then read the same address -> full miss again starting at k=0.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// CPU request, cache SRAM and byte-wide main-memory signals of the cache controller.
// slave = controller side; master = CPU plus the two memories.
interface cache_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_wr_rd;
    logic        cpu_cs;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;

    logic [7:0]  sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;
    logic        sram_wen;

    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_wr_rd;
    logic        mem_strb;

    modport slave (
        input  cpu_addr, cpu_wr_rd, cpu_cs, cpu_dout, sram_dout, mem_dout,
        output cpu_din, cpu_rdy, sram_addr, sram_din, sram_wen,
               mem_addr, mem_din, mem_wr_rd, mem_strb
    );

    modport master (
        output cpu_addr, cpu_wr_rd, cpu_cs, cpu_dout, sram_dout, mem_dout,
        input  cpu_din, cpu_rdy, sram_addr, sram_din, sram_wen,
               mem_addr, mem_din, mem_wr_rd, mem_strb
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller, 8 lines x 32 bytes; hits finish 2 edges after accept.
// Misses stream 32 bytes at (2+MEM_WAIT) cycles each; cs rises while busy are dropped (cpu_rdy=0).
module cache_ctrl #(
    parameter int MEM_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, COMPARE, RD_WAIT, DONE,
        WB_RD, WB_STRB, WB_WAIT,
        FILL_STRB, FILL_WAIT, FILL_WR
    } state_t;

    state_t      state, next_state;
    logic [4:0]  k;
    logic [3:0]  wcnt;
    logic [15:0] req_addr;
    logic        req_wr;
    logic [7:0]  req_data;
    logic [7:0]  cap;
    logic        cs_prev;
    logic [7:0]  tag [8];
    logic [7:0]  valid, dirty;

    logic [7:0]  req_tag;
    logic [2:0]  idx;
    logic [4:0]  off;
    logic        hit, wait_last, accept;

    assign req_tag   = req_addr[15:8];
    assign idx       = req_addr[7:5];
    assign off       = req_addr[4:0];
    assign hit       = valid[idx] && (tag[idx] == req_tag);
    assign wait_last = (wcnt == 4'(MEM_WAIT - 1));
    assign accept    = (state == IDLE) && bus.cpu_cs && !cs_prev;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // SRAM and memory strobes are decoded from state so the SRAM read issued in one
    // state lands on sram_dout in the next.
    always_comb begin
        next_state    = state;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        bus.sram_wen  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_din   = '0;
        bus.mem_wr_rd = 1'b0;
        bus.mem_strb  = 1'b0;
        case (state)
            IDLE: if (accept) next_state = COMPARE;
            COMPARE: begin
                if (hit) begin
                    bus.sram_addr = {idx, off};
                    if (req_wr) begin
                        bus.sram_wen = 1'b1;
                        bus.sram_din = req_data;
                        next_state   = DONE;
                    end else begin
                        next_state   = RD_WAIT;
                    end
                end else if (valid[idx] && dirty[idx]) begin
                    next_state = WB_RD;
                end else begin
                    next_state = FILL_STRB;
                end
            end
            RD_WAIT, DONE: next_state = IDLE;
            WB_RD: begin
                bus.sram_addr = {idx, k};
                next_state    = WB_STRB;
            end
            WB_STRB: begin
                bus.mem_addr  = {tag[idx], idx, k};
                bus.mem_din   = bus.sram_dout;
                bus.mem_wr_rd = 1'b1;
                bus.mem_strb  = 1'b1;
                next_state    = WB_WAIT;
            end
            WB_WAIT: begin
                bus.mem_addr  = {tag[idx], idx, k};
                bus.mem_wr_rd = 1'b1;
                if (wait_last) next_state = (k == 5'd31) ? FILL_STRB : WB_RD;
            end
            FILL_STRB: begin
                bus.mem_addr = {req_tag, idx, k};
                bus.mem_strb = 1'b1;
                next_state   = FILL_WAIT;
            end
            FILL_WAIT: begin
                bus.mem_addr = {req_tag, idx, k};
                if (wait_last) next_state = FILL_WR;
            end
            FILL_WR: begin
                bus.sram_wen  = 1'b1;
                bus.sram_addr = {idx, k};
                bus.sram_din  = cap;
                next_state    = (k == 5'd31) ? COMPARE : FILL_STRB;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k           <= '0;
            wcnt        <= '0;
            req_addr    <= '0;
            req_wr      <= 1'b0;
            req_data    <= '0;
            cap         <= '0;
            cs_prev     <= 1'b0;
            valid       <= '0;
            dirty       <= '0;
            bus.cpu_rdy <= 1'b1;
            bus.cpu_din <= '0;
            for (int i = 0; i < 8; i++) tag[i] <= '0;
        end else begin
            cs_prev <= bus.cpu_cs;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr    <= bus.cpu_addr;
                        req_wr      <= bus.cpu_wr_rd;
                        req_data    <= bus.cpu_dout;
                        bus.cpu_rdy <= 1'b0;
                    end
                end
                COMPARE: begin
                    k    <= '0;
                    wcnt <= '0;
                    if (hit && req_wr) dirty[idx] <= 1'b1;
                end
                RD_WAIT: begin
                    bus.cpu_din <= bus.sram_dout;
                    bus.cpu_rdy <= 1'b1;
                end
                DONE: bus.cpu_rdy <= 1'b1;
                WB_WAIT, FILL_WAIT: begin
                    if (wait_last) begin
                        wcnt <= '0;
                        if (state == FILL_WAIT) cap <= bus.mem_dout;
                        else                    k   <= k + 5'd1;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                FILL_WR: begin
                    // k wraps to 0 after the last word, ready for the next loop
                    k <= k + 5'd1;
                    if (k == 5'd31) begin
                        tag[idx]   <= req_tag;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: vector table of CPU requests plus reset / dropped-request sequences.
module tb_cache_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if bus();
    cache_ctrl #(.MEM_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  mem  [0:65535];
    logic [7:0]  sram [0:255];
    int          rd_cnt, wr_cnt, seq_bad, strb_bad;
    logic [15:0] rd_first, wr_first;
    logic        prev_strb = 1'b0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
        int          nwr;
        int          nrd;
        logic [15:0] wa0;
        logic [15:0] ra0;
        logic [7:0]  din;
    } vec_t;
    vec_t v [8];

    function automatic logic [7:0] memfn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // SRAM and main-memory models; monitor counts strobes and checks address order
    always @(posedge clk) begin
        if (bus.sram_wen) sram[bus.sram_addr] <= bus.sram_din;
        bus.sram_dout <= sram[bus.sram_addr];
        if (bus.mem_strb && prev_strb) strb_bad++;
        prev_strb <= bus.mem_strb;
        if (bus.mem_strb) begin
            if (bus.mem_wr_rd) begin
                if (wr_cnt == 0) wr_first = bus.mem_addr;
                else if (bus.mem_addr != 16'(wr_first + 16'(wr_cnt))) seq_bad++;
                wr_cnt++;
                mem[bus.mem_addr] = bus.mem_din;
            end else begin
                if (rd_cnt == 0) rd_first = bus.mem_addr;
                else if (bus.mem_addr != 16'(rd_first + 16'(rd_cnt))) seq_bad++;
                rd_cnt++;
                bus.mem_dout <= mem[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        rd_cnt = 0; wr_cnt = 0; seq_bad = 0; rd_first = '0; wr_first = '0;
    endtask

    task automatic start_req(input logic wr, input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_wr_rd = wr;
        bus.cpu_dout  = data;
        bus.cpu_cs    = 1'b1;
        clr_mon();
        @(posedge clk);
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.cpu_rdy && n < 2000);
    endtask

    task automatic end_req();
        @(negedge clk);
        bus.cpu_cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n, bad;
        for (int i = 0; i < 65536; i++) mem[i] = memfn(16'(i));
        for (int i = 0; i < 256; i++) sram[i] = 8'h00;
        bus.sram_dout = 8'h00;
        bus.mem_dout  = 8'h00;
        bus.cpu_addr  = '0;
        bus.cpu_wr_rd = 1'b0;
        bus.cpu_dout  = '0;
        bus.cpu_cs    = 1'b0;
        rst = 1'b0;
        clr_mon();
        strb_bad = 0;

        //            wr    addr      data   cyc  nwr nrd  wa0       ra0       din
        v[0] = '{1'b1, 16'h1100, 8'hAA, 195,  0, 32, 16'h0000, 16'h1100, 8'h00};
        v[1] = '{1'b1, 16'h1102, 8'hBB,   2,  0,  0, 16'h0000, 16'h0000, 8'h00};
        v[2] = '{1'b0, 16'h1100, 8'h00,   2,  0,  0, 16'h0000, 16'h0000, 8'hAA};
        v[3] = '{1'b0, 16'h1102, 8'h00,   2,  0,  0, 16'h0000, 16'h0000, 8'hBB};
        v[4] = '{1'b1, 16'h5504, 8'h99, 387, 32, 32, 16'h1100, 16'h5500, 8'hBB};
        v[5] = '{1'b0, 16'h6606, 8'h00, 387, 32, 32, 16'h5500, 16'h6600, 8'h5C};
        v[6] = '{1'b0, 16'h3346, 8'h00, 195,  0, 32, 16'h0000, 16'h3340, 8'h49};
        v[7] = '{1'b0, 16'h4444, 8'h00, 195,  0, 32, 16'h0000, 16'h4440, 8'h3C};

        // reset held while cs toggles: everything quiet and zero
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cpu_cs = (i % 2 == 1);
            @(posedge clk); #1;
            chk("reset_outs",
                {bus.cpu_rdy, bus.cpu_din, bus.mem_strb, bus.sram_wen, bus.sram_addr,
                 bus.sram_din, bus.mem_addr, bus.mem_din, bus.mem_wr_rd},
                {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0});
        end
        chk("reset_no_strobes", 64'(rd_cnt + wr_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start_req(v[i].wr, v[i].addr, v[i].data);
            wait_rdy(n);
            chk($sformatf("v%0d_cycles", i), 64'(n), 64'(v[i].cyc));
            chk($sformatf("v%0d_mem_writes", i), 64'(wr_cnt), 64'(v[i].nwr));
            chk($sformatf("v%0d_mem_reads", i), 64'(rd_cnt), 64'(v[i].nrd));
            chk($sformatf("v%0d_wb_base", i), 64'(wr_first), 64'(v[i].wa0));
            chk($sformatf("v%0d_fill_base", i), 64'(rd_first), 64'(v[i].ra0));
            chk($sformatf("v%0d_addr_seq", i), 64'(seq_bad), 64'd0);
            chk($sformatf("v%0d_cpu_din", i), 64'(bus.cpu_din), 64'(v[i].din));
            if (i == 0) chk("sram_0x00_after_cold_write", 64'(sram[8'h00]), 64'hAA);
            if (i == 4) begin
                chk("wb_mem_1100", 64'(mem[16'h1100]), 64'hAA);
                chk("wb_mem_1102", 64'(mem[16'h1102]), 64'hBB);
                chk("sram_0x04_after_alloc", 64'(sram[8'h04]), 64'h99);
            end
            if (i == 5) chk("wb_mem_5504", 64'(mem[16'h5504]), 64'h99);
            end_req();
        end

        // cs pulse during a fill is dropped; holding cs high afterwards never retriggers
        start_req(1'b0, 16'h2220, 8'h00);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 20) bus.cpu_cs = 1'b0;
            if (n == 21) bus.cpu_cs = 1'b1;
        end while (!bus.cpu_rdy && n < 2000);
        chk("pulse_cycles", 64'(n), 64'd195);
        chk("pulse_mem_reads", 64'(rd_cnt), 64'd32);
        chk("pulse_cpu_din", 64'(bus.cpu_din), 64'h3E);
        clr_mon();
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.cpu_rdy) bad++;
        end
        chk("cs_held_no_retrigger", {32'(rd_cnt + wr_cnt), 32'(bad)}, 64'd0);
        end_req();

        // reset in the middle of a fill, then the same address misses from k=0
        start_req(1'b0, 16'h7720, 8'h00);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rd_cnt < 11 && n < 200);
        chk("fill_reached_k10", 64'(rd_cnt), 64'd11);
        rst = 1'b0;
        bus.cpu_cs = 1'b0;
        @(posedge clk); #1;
        chk("midfill_reset_outs", {bus.cpu_rdy, bus.mem_strb, bus.sram_wen}, {1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_req(1'b0, 16'h7720, 8'h00);
        wait_rdy(n);
        chk("refill_cycles", 64'(n), 64'd195);
        chk("refill_mem_reads", 64'(rd_cnt), 64'd32);
        chk("refill_mem_writes", 64'(wr_cnt), 64'd0);
        chk("refill_base", 64'(rd_first), 64'h7720);
        chk("refill_cpu_din", 64'(bus.cpu_din), 64'h6B);
        end_req();

        chk("strobe_single_cycle", 64'(strb_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
